// File: rtl/sdc_pkg.sv
// Shared types and constants for the SD card controller data paths.
// The serial CRC16 step is kept here so the read and write paths use one definition.
package sdc_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
    S_CRC,
    S_END,
    S_WAIT_RESP,
    S_RESP,
    S_BUSY,
    S_FIN
  } sdc_wr_state_e;

  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [2:0]  TOKEN_OK      = 3'b010;
  localparam logic [2:0]  TOKEN_CRC_ERR = 3'b101;
  localparam logic [2:0]  TOKEN_WR_ERR  = 3'b110;
  localparam int unsigned BLK_BITS      = 4096;

  // One bit of CCITT CRC16 (x^16+x^12+x^5+1), MSB-first serial form.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sdc_crc16_serial.sv
// Bit-serial CRC16 accumulator for the SD DAT lines.
// clr has priority over en; the value holds when en is low.
module sdc_crc16_serial
  import sdc_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc16_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/sdc_blk_wr_dat.sv
// SD write data path: serializes one block from block RAM onto DAT0 (1-bit mode),
// then captures the card's CRC status token and waits out card busy.
module sdc_blk_wr_dat
  import sdc_pkg::*;
#(
  parameter int unsigned BLK_WORDS    = 64,
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned TIMEOUT_CLKS = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] blk_base_addr,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [63:0]       bram_rd_data,
  input  logic              sd_clk_en,
  output logic              dat_out,
  output logic              dat_oe,
  input  logic              dat_in,
  output logic              busy,
  output logic              done,
  output logic [2:0]        crc_status,
  output logic              crc_ok,
  output logic              timeout
);

  localparam int unsigned TOTAL_BITS = BLK_WORDS * 64;
  localparam int unsigned CNT_W      = $clog2(TOTAL_BITS);
  localparam int unsigned TO_W       = $clog2(TIMEOUT_CLKS + 1);

  sdc_wr_state_e state_q, state_d;

  logic [63:0]       shift_q;
  logic [63:0]       hold_q;
  logic [1:0]        fetch_cnt;
  logic              refill_d1;
  logic              refill_d2;
  logic [CNT_W-1:0]  cnt_q;
  logic [TO_W-1:0]   to_cnt;
  logic [15:0]       crc;
  logic              crc_clr;
  logic              crc_en;
  logic              to_last;
  logic              word_end;
  logic              reload;
  logic              prefetch;

  assign to_last  = (to_cnt == TO_W'(TIMEOUT_CLKS - 1));
  assign word_end = (cnt_q[5:0] == 6'd63);
  // Final word is already in the shifter, and the holding register already has it
  // one word earlier, so reload/prefetch stop short of the block end.
  assign reload   = word_end && (cnt_q < CNT_W'(TOTAL_BITS - 64));
  assign prefetch = word_end && (cnt_q < CNT_W'(TOTAL_BITS - 128));

  assign crc_clr = reset || ((state_q == S_START) && sd_clk_en);
  assign crc_en  = (state_q == S_DATA) && sd_clk_en;

  sdc_crc16_serial u_crc (
    .clk    (clk),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (shift_q[63]),
    .crc    (crc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_FETCH;
      S_FETCH:     if (fetch_cnt == 2'd2) state_d = S_START;
      S_START:     if (sd_clk_en) state_d = S_DATA;
      S_DATA:      if (sd_clk_en && (cnt_q == CNT_W'(TOTAL_BITS - 1))) state_d = S_CRC;
      S_CRC:       if (sd_clk_en && (cnt_q == CNT_W'(15))) state_d = S_END;
      S_END:       if (sd_clk_en && (cnt_q == CNT_W'(1))) state_d = S_WAIT_RESP;
      S_WAIT_RESP: if (sd_clk_en) begin
                     if (!dat_in)      state_d = S_RESP;
                     else if (to_last) state_d = S_FIN;
                   end
      S_RESP:      if (sd_clk_en && (cnt_q == CNT_W'(3))) state_d = S_BUSY;
      S_BUSY:      if (sd_clk_en && (dat_in || to_last)) state_d = S_FIN;
      S_FIN:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bram_addr  <= '0;
      dat_out    <= 1'b1;
      dat_oe     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      crc_status <= '0;
      crc_ok     <= 1'b0;
      timeout    <= 1'b0;
      shift_q    <= '0;
      hold_q     <= '0;
      fetch_cnt  <= '0;
      refill_d1  <= 1'b0;
      refill_d2  <= 1'b0;
      cnt_q      <= '0;
      to_cnt     <= '0;
    end else begin
      state_q   <= state_d;
      done      <= 1'b0;
      refill_d1 <= 1'b0;
      refill_d2 <= refill_d1;
      // RAM data for a newly issued address is registered two clocks later.
      if (refill_d2) hold_q <= bram_rd_data;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            bram_addr  <= blk_base_addr;
            busy       <= 1'b1;
            crc_status <= '0;
            crc_ok     <= 1'b0;
            timeout    <= 1'b0;
            fetch_cnt  <= '0;
          end
        end
        S_FETCH: begin
          fetch_cnt <= fetch_cnt + 2'd1;
          case (fetch_cnt)
            2'd0:    bram_addr <= bram_addr + ADDR_W'(1);
            2'd1:    shift_q   <= bram_rd_data;
            2'd2:    hold_q    <= bram_rd_data;
            default: ;
          endcase
        end
        S_START: begin
          if (sd_clk_en) begin
            dat_oe  <= 1'b1;
            dat_out <= 1'b0;
            cnt_q   <= '0;
          end
        end
        S_DATA: begin
          if (sd_clk_en) begin
            dat_out <= shift_q[63];
            cnt_q   <= (cnt_q == CNT_W'(TOTAL_BITS - 1)) ? '0 : cnt_q + CNT_W'(1);
            if (reload) shift_q <= hold_q;
            else        shift_q <= {shift_q[62:0], 1'b0};
            if (prefetch) begin
              bram_addr <= bram_addr + ADDR_W'(1);
              refill_d1 <= 1'b1;
            end
          end
        end
        S_CRC: begin
          if (sd_clk_en) begin
            dat_out <= crc[4'd15 - cnt_q[3:0]];
            cnt_q   <= (cnt_q == CNT_W'(15)) ? '0 : cnt_q + CNT_W'(1);
          end
        end
        S_END: begin
          if (sd_clk_en) begin
            dat_out <= 1'b1;
            if (cnt_q == '0) begin
              cnt_q <= CNT_W'(1);
            end else begin
              dat_oe <= 1'b0;
              cnt_q  <= '0;
              to_cnt <= '0;
            end
          end
        end
        S_WAIT_RESP: begin
          if (sd_clk_en) begin
            if (!dat_in)      cnt_q   <= '0;
            else if (to_last) timeout <= 1'b1;
            else              to_cnt  <= to_cnt + TO_W'(1);
          end
        end
        S_RESP: begin
          if (sd_clk_en) begin
            if (cnt_q != CNT_W'(3)) begin
              crc_status <= {crc_status[1:0], dat_in};
              cnt_q      <= cnt_q + CNT_W'(1);
            end else begin
              cnt_q  <= '0;
              to_cnt <= '0;
            end
          end
        end
        S_BUSY: begin
          if (sd_clk_en && !dat_in) begin
            if (to_last) timeout <= 1'b1;
            else         to_cnt  <= to_cnt + TO_W'(1);
          end
        end
        S_FIN: begin
          done   <= 1'b1;
          busy   <= 1'b0;
          crc_ok <= (crc_status == TOKEN_OK);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdc_blk_wr_dat.sv
// Self-checking bench for sdc_blk_wr_dat: RAM and SD card models, frame capture,
// reference CRC by polynomial division, table of block transfers plus a reset sequence.
module tb_sdc_blk_wr_dat;
  import sdc_pkg::*;

  localparam int unsigned AW = 11;
  localparam int unsigned TO = 100;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] blk_base_addr;
  logic [AW-1:0] bram_addr;
  logic [63:0]   bram_rd_data;
  logic          sd_clk_en;
  logic          dat_out;
  logic          dat_oe;
  logic          dat_in;
  logic          busy;
  logic          done;
  logic [2:0]    crc_status;
  logic          crc_ok;
  logic          timeout;

  sdc_blk_wr_dat #(.BLK_WORDS(64), .ADDR_W(AW), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .blk_base_addr(blk_base_addr),
    .bram_addr(bram_addr), .bram_rd_data(bram_rd_data), .sd_clk_en(sd_clk_en),
    .dat_out(dat_out), .dat_oe(dat_oe), .dat_in(dat_in), .busy(busy), .done(done),
    .crc_status(crc_status), .crc_ok(crc_ok), .timeout(timeout)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [0:2047];
  always @(posedge clk) bram_rd_data <= mem[bram_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SD clock strobes: one clk high, then 1 or 2 clk low.
  initial begin
    int gap;
    gap = 0;
    sd_clk_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (gap == 0) begin
        sd_clk_en = 1'b1;
        gap = ($urandom_range(0, 7) == 0) ? 2 : 1;
      end else begin
        sd_clk_en = 1'b0;
        gap--;
      end
    end
  end

  bit            frame[$];
  bit            card_q[$];
  bit            card_tail;
  bit            oe_prev;
  bit            released;
  int            resp_strobes;
  logic [AW-1:0] addr_q[$];
  bit            addr_seen;

  // Line capture while driven; card replies one bit per strobe after release.
  initial begin
    forever begin
      @(posedge clk);
      if (sd_clk_en && !reset) begin
        #1;
        if (dat_oe) begin
          frame.push_back(dat_out);
          oe_prev = 1'b1;
        end else if (oe_prev && !released) begin
          released = 1'b1;
        end else if (released && busy) begin
          resp_strobes++;
        end
        if (released) dat_in = (card_q.size() > 0) ? card_q.pop_front() : card_tail;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (busy && (!addr_seen || bram_addr != addr_q[$])) begin
        addr_q.push_back(bram_addr);
        addr_seen = 1'b1;
      end
    end
  end

  task automatic clear_line();
    frame.delete();
    card_q.delete();
    card_tail    = 1'b1;
    oe_prev      = 1'b0;
    released     = 1'b0;
    resp_strobes = 0;
    addr_q.delete();
    addr_seen    = 1'b0;
    dat_in       = 1'b1;
  endtask

  bit          data_q[$];
  bit          exp_frame[$];
  logic [15:0] exp_crc;

  // Remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
  function automatic logic [15:0] model_crc();
    logic [16:0] r;
    r = '0;
    for (int i = 0; i < data_q.size() + 16; i++) begin
      r = {r[15:0], (i < data_q.size()) ? data_q[i] : 1'b0};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  task automatic build_exp(input logic [AW-1:0] base);
    logic [63:0]   word;
    logic [AW-1:0] a;
    data_q.delete();
    exp_frame.delete();
    for (int w = 0; w < 64; w++) begin
      a    = base + AW'(w);
      word = mem[a];
      for (int b = 63; b >= 0; b--) data_q.push_back(word[b]);
    end
    exp_crc = model_crc();
    exp_frame.push_back(1'b0);
    foreach (data_q[i]) exp_frame.push_back(data_q[i]);
    for (int b = 15; b >= 0; b--) exp_frame.push_back(exp_crc[b]);
    exp_frame.push_back(1'b1);
  endtask

  task automatic fill_mem(input int pat);
    for (int a = 0; a < 2048; a++) begin
      case (pat)
        0:       mem[a] = 64'h0;
        1:       mem[a] = 64'hFFFF_FFFF_FFFF_FFFF;
        2:       mem[a] = 64'(a);
        default: mem[a] = {$urandom(), $urandom()};
      endcase
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] base);
    @(posedge clk);
    #1;
    blk_base_addr = base;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] base;
    int            pat;
    logic [2:0]    tok;
    int            gap;
    int            busy_n;
    bit            no_card;
    bit            stuck;
    bit            fixed_chk;
    logic [15:0]   fixed_crc;
    logic [2:0]    exp_status;
    bit            exp_ok;
    bit            exp_to;
  } vec_t;

  vec_t tbl[6];

  task automatic run_xfer(input vec_t v, input int idx);
    int got;
    int bad;
    int exp_cnt;
    logic [63:0] w0;
    string tag;
    tag = $sformatf("v%0d", idx);
    fill_mem(v.pat);
    clear_line();
    if (!v.no_card) begin
      repeat (v.gap) card_q.push_back(1'b1);
      card_q.push_back(1'b0);
      card_q.push_back(v.tok[2]);
      card_q.push_back(v.tok[1]);
      card_q.push_back(v.tok[0]);
      card_q.push_back(1'b1);
      if (!v.stuck) repeat (v.busy_n) card_q.push_back(1'b0);
      card_tail = !v.stuck;
    end
    build_exp(v.base);
    if (v.no_card)    exp_cnt = TO;
    else if (v.stuck) exp_cnt = v.gap + 5 + TO;
    else              exp_cnt = v.gap + 5 + v.busy_n + 1;

    pulse_start(v.base);
    check({tag, "_busy_start"}, 64'(busy), 64'(1));
    got = 0;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    check({tag, "_done_seen"}, 64'(got), 64'(1));
    check({tag, "_status"}, 64'(crc_status), 64'(v.exp_status));
    check({tag, "_crc_ok"}, 64'(crc_ok), 64'(v.exp_ok));
    check({tag, "_timeout"}, 64'(timeout), 64'(v.exp_to));
    check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'(0));

    check({tag, "_frame_len"}, 64'(frame.size()), 64'(1 + BLK_BITS + 16 + 1));
    bad = 0;
    foreach (exp_frame[i]) if (i >= frame.size() || frame[i] != exp_frame[i]) bad++;
    check({tag, "_frame_bits_bad"}, 64'(bad), 64'(0));
    if (v.fixed_chk) check({tag, "_crc_value"}, 64'(exp_crc), 64'(v.fixed_crc));
    if (v.pat == 2 && frame.size() > 64) begin
      for (int b = 0; b < 64; b++) w0[63-b] = frame[1+b];
      check({tag, "_first_word"}, w0, 64'(v.base));
    end
    check({tag, "_resp_strobes"}, 64'(resp_strobes), 64'(exp_cnt));
    bad = (addr_q.size() == 64) ? 0 : 1;
    foreach (addr_q[i]) if (addr_q[i] != AW'(v.base + AW'(i))) bad++;
    check({tag, "_addr_seq_bad"}, 64'(bad), 64'(0));
  endtask

  task automatic reset_mid_data();
    int reached;
    int bad;
    fill_mem(3);
    clear_line();
    build_exp(11'd300);
    pulse_start(11'd300);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (frame.size() >= 501) break;
    end
    pulse_start(11'd5);
    reached = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (frame.size() >= 1001) begin
        reached = 1;
        break;
      end
    end
    check("rst_reach_bit1000", 64'(reached), 64'(1));
    check("rst_busy_before", 64'(busy), 64'(1));
    bad = 0;
    for (int i = 0; i < 1001; i++) if (i >= frame.size() || frame[i] != exp_frame[i]) bad++;
    check("rst_prefix_bad", 64'(bad), 64'(0));
    bad = 0;
    foreach (addr_q[i]) if (addr_q[i] != AW'(11'd300 + AW'(i))) bad++;
    check("rst_addr_prefix_bad", 64'(bad), 64'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_dat_oe", 64'(dat_oe), 64'(0));
    check("rst_dat_out", 64'(dat_out), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_bram_addr", 64'(bram_addr), 64'(0));
    reset = 1'b0;
    clear_line();
  endtask

  initial begin
    tbl[0] = '{11'd0,    0, TOKEN_OK,      2, 4,  1'b0, 1'b0, 1'b1, 16'h0000, 3'b010, 1'b1, 1'b0};
    tbl[1] = '{11'd0,    1, TOKEN_OK,      1, 4,  1'b0, 1'b0, 1'b1, 16'h7FA1, 3'b010, 1'b1, 1'b0};
    tbl[2] = '{11'd1000, 2, TOKEN_OK,      3, 10, 1'b0, 1'b0, 1'b0, 16'h0000, 3'b010, 1'b1, 1'b0};
    tbl[3] = '{11'd2040, 2, TOKEN_CRC_ERR, 1, 6,  1'b0, 1'b0, 1'b0, 16'h0000, 3'b101, 1'b0, 1'b0};
    tbl[4] = '{11'd123,  3, TOKEN_OK,      0, 0,  1'b1, 1'b0, 1'b0, 16'h0000, 3'b000, 1'b0, 1'b1};
    tbl[5] = '{11'd7,    3, TOKEN_WR_ERR,  2, 0,  1'b0, 1'b1, 1'b0, 16'h0000, 3'b110, 1'b0, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    blk_base_addr = '0;
    fill_mem(0);
    clear_line();
    repeat (3) @(posedge clk);
    #1;
    check("reset_bram_addr", 64'(bram_addr), 64'(0));
    check("reset_dat_out", 64'(dat_out), 64'(1));
    check("reset_dat_oe", 64'(dat_oe), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_status", 64'(crc_status), 64'(0));
    check("reset_crc_ok", 64'(crc_ok), 64'(0));
    check("reset_timeout", 64'(timeout), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);

    reset_mid_data();
    repeat (4) @(posedge clk);
    for (int i = 0; i < 6; i++) run_xfer(tbl[i], i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdc_blk_wr_dat.md
Name: sdc_blk_wr_dat

Overview:
- Write-direction data path of the SD card controller, the counterpart of the read path that fills the 1040x64 block RAM.
- Reads one 512-byte block (64 x 64-bit words) from block RAM port B and serializes it onto DAT0 in 1-bit SD mode: start bit, 4096 data bits, CRC16, end bit.
- Then releases the line, captures the card's 3-bit CRC status token and waits out card busy.
- Sits between the block RAM and the SD pad/clock-enable logic; the command sequencer starts it after CMD24/CMD25 is accepted.

Parameters:
BLK_WORDS, 64, 64-bit words per block
ADDR_W, 11, block RAM address width
TIMEOUT_CLKS, 65535, max sd_clk_en strobes in WAIT_RESP or BUSY before timeout

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse, begin block transfer (ignored unless idle)
blk_base_addr  in  ADDR_W  first word address in block RAM
bram_addr  out  ADDR_W  block RAM port B address
bram_rd_data  in  64  block RAM port B data, valid 1 clk after bram_addr
sd_clk_en  in  1  one-clk strobe per SD clock; line updates/samples only on strobe; min spacing 2 clk
dat_out  out  1  DAT0 drive value
dat_oe  out  1  DAT0 output enable
dat_in  in  1  DAT0 sampled value
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
crc_status  out  3  captured status token
crc_ok  out  1  crc_status == 3'b010, valid with done
timeout  out  1  set with done if the card did not respond or stayed busy

Behaviour:
- Reset values (reset is synchronous, active-high, one clock `clk`):
  - bram_addr=0, dat_out=1, dat_oe=0.
  - busy=0, done=0, crc_status=0, crc_ok=0, timeout=0.
  - FSM returns to IDLE.
- Reset mid-transfer: same values next clk; the line is released immediately.
- FSM states: IDLE, FETCH, START, DATA, CRC, END, WAIT_RESP, RESP, BUSY, FIN.
- IDLE:
  - On start, latch base, set bram_addr=blk_base_addr, busy=1, clear crc_status/crc_ok/timeout, go FETCH.
  - start in any other state is ignored.
- FETCH:
  - 2 clk later load shift register with word 0.
  - Issue bram_addr=base+1 and load holding register 1 clk after.
  - Go START.
- START: on next sd_clk_en, dat_oe=1, dat_out=0, clear CRC to 16'h0000, go DATA.
- DATA: each sd_clk_en:
  - dat_out=shift[63]; CRC updated with that bit; shift left.
  - Word bit 63 is sent first.
  - After bit 0 of a word: reload shift from holding register, advance bram_addr, refill holding register within 2 clk (guaranteed by strobe spacing).
  - bram_addr wraps modulo 2^ADDR_W.
  - After 4096 bits go CRC.
- CRC: 16 strobes, CRC MSB first; CRC = CCITT x^16+x^12+x^5+1, init 0.
- END: one strobe dat_out=1; next strobe dat_oe=0, go WAIT_RESP.
- WAIT_RESP: on each strobe sample dat_in; first 0 -> RESP. Count strobes; at TIMEOUT_CLKS set timeout, go FIN.
- RESP:
  - Next 3 strobes shift dat_in into crc_status, MSB first.
  - Skip 1 end-bit strobe, then go BUSY.
- BUSY:
  - Wait for dat_in=1 on a strobe, then go FIN.
  - Timeout counter restarts on entering BUSY; on expiry set timeout, go FIN.
- FIN: done=1 for one clk, busy=0, crc_ok=(crc_status==3'b010), go IDLE.
- Status token meanings:
  - 010 = accepted.
  - 101 = CRC error.
  - 110 = write error; reported, not retried here.

Decomposition:
- Package sdc_pkg holds:
  - state enum;
  - CRC16_POLY=16'h1021;
  - TOKEN_OK=3'b010, TOKEN_CRC_ERR=3'b101, TOKEN_WR_ERR=3'b110;
  - BLK_BITS=4096.
- Sub-module sdc_crc16_serial (clr, en, bit_in, crc[15:0]) is natural and shareable with the read path.

Test Plan:
- Block RAM all words 64'h0, base=0, card model returns 010 then 4-strobe busy -> 4096 zero bits, CRC 16'h0000, end bit 1, done with crc_ok=1, timeout=0.
- Block RAM all bytes 8'hFF (words 64'hFFFF_FFFF_FFFF_FFFF) -> serialized CRC 16'h7FA1, frame length 1+4096+16+1 strobes.
- base=11'd1000, words = address index -> bram_addr sequence 1000..1063, first data bits match 64'd1000 MSB-first; base=11'd2040 checks wrap to 0.
- Card returns 101 -> crc_status=3'b101, crc_ok=0, done asserted after busy release.
- Card never drives start bit (dat_in=1), TIMEOUT_CLKS=100 -> timeout=1 and done after 100 strobes in WAIT_RESP; busy stuck low gives the same in BUSY.
- reset asserted mid-DATA (bit 1000) -> next clk dat_oe=0, busy=0; new start works normally; start pulse during DATA is ignored.
